// File: rtl/mips_pkg.sv
// Shared MIPS writeback definitions: register addressing and the buffered
// write entry carried through the MDU result FIFO.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int WB_WIDTH = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic [WB_WIDTH-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending MDU writes with squash-by-destination and a
// destination-match query used for hazard detection.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  wb_entry_t                 push_entry,
    input  logic                      pop,
    output wb_entry_t                 head,
    input  logic                      squash,
    input  logic [REG_ADDR_W-1:0]     squash_dest,
    input  logic [REG_ADDR_W-1:0]     query_dest,
    output logic                      query_hit,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]      valid_q;
    logic [REG_ADDR_W-1:0] dest_q [DEPTH];
    logic [WB_WIDTH-1:0]   data_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;

    // Free slots always hold valid=0 (cleared on pop), so the match query
    // and squash never need to know which slots are occupied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            // NOTE: non-blocking assignments let the later pop/push writes
            // to the same slot override the squash loop within one cycle.
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && valid_q[i] && dest_q[i] == squash_dest)
                    valid_q[i] <= 1'b0;
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                valid_q[wr_ptr] <= push_entry.valid;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the payload array has no reset; it is only observed through
    // valid_q, which is reset, so resetting it would add nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr] <= push_entry.dest;
            data_q[wr_ptr] <= push_entry.data;
        end
    end

    always_comb begin
        head.valid = valid_q[rd_ptr];
        head.dest  = dest_q[rd_ptr];
        head.data  = data_q[rd_ptr];
    end

    always_comb begin
        // NOTE: default first so every path assigns it and no latch forms.
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && dest_q[i] == query_dest)
                query_hit = 1'b1;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: ALU results take priority, MDU results
// wait in wb_fifo, and same-register ordering is kept by squashing older MDU writes.
module writeback_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   aluValid,
    input  logic [REG_ADDR_W-1:0]  aluDest,
    input  logic [WIDTH-1:0]       aluResult,
    input  logic                   mduValid,
    output logic                   mduReady,
    input  logic [REG_ADDR_W-1:0]  mduDest,
    input  logic [WIDTH-1:0]       mduResult,
    output logic                   RegisterWrite,
    output logic [REG_ADDR_W-1:0]  writeRegister,
    output logic [WIDTH-1:0]       writeBack,
    input  logic [REG_ADDR_W-1:0]  pendingQuery,
    output logic                   pendingHit,
    output logic [$clog2(DEPTH):0] fifoCount
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic      alu_take;
    logic      mdu_fire;
    logic      push;
    logic      pop;
    logic      fifo_hit;
    wb_entry_t push_entry;
    wb_entry_t head;

    assign alu_take = aluValid && (aluDest != REG_ZERO);
    assign mduReady = rst && (fifoCount != CNT_W'(DEPTH));
    assign mdu_fire = mduValid && mduReady;

    // An MDU result racing a same-register ALU write is older, so it is dropped.
    assign push = mdu_fire && (mduDest != REG_ZERO)
                  && !(alu_take && (mduDest == aluDest));
    assign pop  = !alu_take && (fifoCount != '0);

    always_comb begin
        push_entry.valid = 1'b1;
        push_entry.dest  = mduDest;
        push_entry.data  = WB_WIDTH'(mduResult);
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .squash      (alu_take),
        .squash_dest (aluDest),
        .query_dest  (pendingQuery),
        .query_hit   (fifo_hit),
        .count       (fifoCount)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegisterWrite <= 1'b0;
            writeRegister <= REG_ZERO;
            writeBack     <= '0;
        end else if (alu_take) begin
            RegisterWrite <= 1'b1;
            writeRegister <= aluDest;
            writeBack     <= aluResult;
        end else if (pop) begin
            RegisterWrite <= head.valid;
            if (head.valid) begin
                writeRegister <= head.dest;
                writeBack     <= WIDTH'(head.data);
            end
        end else begin
            RegisterWrite <= 1'b0;
        end
    end

    assign pendingHit = (pendingQuery != REG_ZERO)
                        && (fifo_hit || (RegisterWrite && (writeRegister == pendingQuery)));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a queue-based model of pending MDU
// writes predicts every cycle's outputs; a negedge monitor compares them.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic                   clk;
    logic                   rst;
    logic                   aluValid;
    logic [4:0]             aluDest;
    logic [WIDTH-1:0]       aluResult;
    logic                   mduValid;
    logic                   mduReady;
    logic [4:0]             mduDest;
    logic [WIDTH-1:0]       mduResult;
    logic                   RegisterWrite;
    logic [4:0]             writeRegister;
    logic [WIDTH-1:0]       writeBack;
    logic [4:0]             pendingQuery;
    logic                   pendingHit;
    logic [$clog2(DEPTH):0] fifoCount;

    writeback_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .aluValid      (aluValid),
        .aluDest       (aluDest),
        .aluResult     (aluResult),
        .mduValid      (mduValid),
        .mduReady      (mduReady),
        .mduDest       (mduDest),
        .mduResult     (mduResult),
        .RegisterWrite (RegisterWrite),
        .writeRegister (writeRegister),
        .writeBack     (writeBack),
        .pendingQuery  (pendingQuery),
        .pendingHit    (pendingHit),
        .fifoCount     (fifoCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  d;
        logic [31:0] data;
    } m_ent_t;

    typedef struct {
        logic        we;
        logic [4:0]  d;
        logic [31:0] data;
        int          cnt;
        logic        rdy;
        logic        hit;
    } exp_t;

    // Model: pending MDU results in program order plus the last write issued.
    m_ent_t      mq[$];
    logic        m_we;
    logic [4:0]  m_d;
    logic [31:0] m_data;
    exp_t        sb[$];
    logic [31:0] rf [32];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_d    = 5'd0;
        m_data = 32'd0;
    endtask

    task automatic model_update(input logic av, input logic [4:0] ad, input logic [31:0] ar,
                                input logic mv, input logic [4:0] md, input logic [31:0] mr);
        logic   ready;
        logic   alu_w;
        m_ent_t e;
        ready = (mq.size() != DEPTH);
        alu_w = av && (ad != 5'd0);
        if (alu_w) begin
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].d == ad) mq[i].v = 1'b0;
            m_we = 1'b1; m_d = ad; m_data = ar;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = e.v;
            if (e.v) begin m_d = e.d; m_data = e.data; end
        end else begin
            m_we = 1'b0;
        end
        if (mv && ready && md != 5'd0 && !(alu_w && md == ad))
            mq.push_back('{v: 1'b1, d: md, data: mr});
    endtask

    function automatic logic model_hit(input logic [4:0] q);
        logic h;
        h = m_we && (m_d == q);
        foreach (mq[i]) if (mq[i].v && mq[i].d == q) h = 1'b1;
        return (q != 5'd0) && h;
    endfunction

    // Called just after a posedge: drives one cycle of inputs, records the
    // outputs expected at the coming negedge, then advances the model.
    task automatic cycle(input logic av, input logic [4:0] ad, input logic [31:0] ar,
                         input logic mv, input logic [4:0] md, input logic [31:0] mr,
                         input logic [4:0] q);
        exp_t x;
        aluValid = av; aluDest = ad; aluResult = ar;
        mduValid = mv; mduDest = md; mduResult = mr;
        pendingQuery = q;
        x.we = m_we; x.d = m_d; x.data = m_data;
        x.cnt = mq.size(); x.rdy = (mq.size() != DEPTH); x.hit = model_hit(q);
        sb.push_back(x);
        @(posedge clk);
        model_update(av, ad, ar, mv, md, mr);
        #1;
    endtask

    task automatic idle(input logic [4:0] q);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_we"},    32'(RegisterWrite), 32'd0);
        check({tag, "_dest"},  32'(writeRegister), 32'd0);
        check({tag, "_data"},  writeBack,          32'd0);
        check({tag, "_count"}, 32'(fifoCount),     32'd0);
        check({tag, "_ready"}, 32'(mduReady),      32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst && RegisterWrite) rf[writeRegister] = writeBack;
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("we", 32'(RegisterWrite), 32'(e.we));
            check("dest", 32'(writeRegister), 32'(e.d));
            check("data", writeBack, e.data);
            check("count", 32'(fifoCount), 32'(e.cnt));
            check("ready", 32'(mduReady), 32'(e.rdy));
            check("hit", 32'(pendingHit), 32'(e.hit));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        aluValid = 1'b0; aluDest = 5'd0; aluResult = '0;
        mduValid = 1'b0; mduDest = 5'd0; mduResult = '0;
        pendingQuery = 5'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_we",    32'(RegisterWrite), 32'd0);
        check("rst_dest",  32'(writeRegister), 32'd0);
        check("rst_data",  writeBack,          32'd0);
        check("rst_count", 32'(fifoCount),     32'd0);
        check("rst_ready", 32'(mduReady),      32'd0);
        rst = 1'b1;
        idle(5'd0);
        idle(5'd0);

        // ALU only
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5);
        idle(5'd5);
        check("rf5_readback", rf[5], 32'hDEADBEEF);
        idle(5'd5);

        // Contention: buffered MDU write waits behind three ALU writes
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11, 5'd7);
        cycle(1'b1, 5'd8, 32'h801, 1'b0, 5'd0, 32'd0, 5'd7);
        cycle(1'b1, 5'd8, 32'h802, 1'b0, 5'd0, 32'd0, 5'd7);
        cycle(1'b1, 5'd8, 32'h803, 1'b0, 5'd0, 32'd0, 5'd7);
        repeat (3) idle(5'd7);

        // Squash: younger ALU write to r9 kills the buffered MDU write
        cycle(1'b1, 5'd10, 32'h1, 1'b1, 5'd9, 32'hAAAA, 5'd9);
        cycle(1'b1, 5'd9, 32'hBBBB, 1'b0, 5'd0, 32'd0, 5'd9);
        repeat (3) idle(5'd9);

        // Same-cycle ALU/MDU to one register: MDU result dropped
        cycle(1'b1, 5'd20, 32'h2020, 1'b1, 5'd20, 32'h9999, 5'd20);
        repeat (2) idle(5'd20);

        // Full / backpressure with ALU held busy
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b1, 5'd12, 32'(i), 1'b1, 5'(13 + i), 32'h100 + 32'(i), 5'd13);
        repeat (DEPTH + 2) idle(5'd14);

        // $0 writes never issue
        cycle(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77, 5'd0);
        repeat (2) idle(5'd0);

        // Randomized traffic with a reset in the middle
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset("midrst");
            cycle($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)));
        end
        repeat (DEPTH + 2) idle(5'd1);

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Write-side initiator for the MIPS register file. Merges single-cycle ALU results and multi-cycle multiply/divide (MDU) results into the one register-file write port, driving `RegisterWrite`/`writeRegister`/`writeBack`. Buffers MDU results in a small FIFO while the ALU holds the port, and preserves program order for writes to the same register. Also reports pending writes to a queried register for hazard detection.

## Interface

- `DEPTH`, 4: MDU FIFO entries; power of two, at least 2.
- `WIDTH`, 32: data width.

- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `aluValid` in 1: ALU result present this cycle; no backpressure.
- `aluDest` in 5: ALU destination register.
- `aluResult` in WIDTH: ALU result.
- `mduValid` in 1: MDU result offered.
- `mduReady` out 1: FIFO can accept; transfer when `mduValid && mduReady`.
- `mduDest` in 5: MDU destination register.
- `mduResult` in WIDTH: MDU result.
- `RegisterWrite` out 1: register-file write enable, registered.
- `writeRegister` out 5: write address, registered.
- `writeBack` out WIDTH: write data, registered.
- `pendingQuery` in 5: register number to check.
- `pendingHit` out 1: combinational; a write to `pendingQuery` is still outstanding.
- `fifoCount` out log2(DEPTH)+1: number of occupied FIFO slots.

## Operation

- **Reset (`rst` low):** `RegisterWrite`=0, `writeRegister`=0, `writeBack`=0, FIFO empty, `fifoCount`=0. `mduReady`=0 while `rst` is low.
- **`mduReady`:** `rst && (fifoCount != DEPTH)`. It depends only on registered count. No push/pop bypass when full.
- **Push:** an accepted MDU transfer writes {valid=1, mduDest, mduResult} at the tail.
  - If `mduDest`==0, the handshake completes but nothing is stored.
- **Port selection each cycle (priority order):**
  - **ALU:** `aluValid && aluDest!=0` loads the ALU result into the output register with `RegisterWrite`=1.
  - **FIFO head:** otherwise, if the FIFO is non-empty, pop the head.
    - Head valid: load it into the output register with `RegisterWrite`=1.
    - Head squashed: discard it and set `RegisterWrite`=0.
  - **Idle:** otherwise `RegisterWrite`=0, and `writeRegister`/`writeBack` hold their previous values.
- **Ordering rule:** an ALU write is younger than every MDU result already buffered or offered in the same cycle.
  - When an ALU write to register R is taken, every valid FIFO entry with dest R is squashed (valid cleared) in that cycle.
  - An MDU result to R accepted in that same cycle is dropped: the handshake completes, nothing is stored.
- **Slot accounting:** squashed entries still occupy a slot until popped. At most one pop per cycle.
- **`$0`:** writes to register 0 are never issued.
- **`pendingHit`:** 1 when `pendingQuery`!=0 and either:
  - `pendingQuery` matches any valid FIFO entry, or
  - it matches `writeRegister` while `RegisterWrite`=1.
  - The current-cycle ALU/MDU inputs are not included.
- **Reset mid-operation:** the FIFO contents are lost and outputs go to their reset values immediately (asynchronous). No write is issued on the cycle reset deasserts.

## Timing

- **ALU latency:** result presented in cycle N appears on the outputs after posedge N+1. The register file captures it at the following negedge.
- **MDU latency:** accepted in cycle N, visible at the FIFO head in N+1, on the outputs after posedge N+2 at the earliest. Each ALU write in between delays it one cycle.
- **Throughput:** one register-file write per cycle maximum. `RegisterWrite` is high for exactly one cycle per issued write.
- **Simultaneous push and pop:** allowed in the same cycle; `fifoCount` stays unchanged.
- **Stall bound:** continuous ALU traffic starves the FIFO; `mduReady` falls after DEPTH accepted results.

## Structure

- **Shared package `mips_pkg`:**
  - `REG_ZERO` = 5'd0.
  - `REG_ADDR_W` = 5.
  - `wb_entry_t` typedef = {valid, dest[4:0], data[WIDTH-1:0]}.
- **Sub-module `wb_fifo`:** circular buffer of `wb_entry_t` with:
  - push/pop ports;
  - squash-by-dest port (address plus strobe);
  - a match-query port for `pendingHit`;
  - count output.
- **Top level:** priority selection, `$0` filtering and the output register.

## Test plan

- **Reset:** assert `rst`=0 mid-burst. Required: outputs 0, `fifoCount`=0, `mduReady`=0. After release: `mduReady`=1 and no spurious `RegisterWrite`.
- **ALU only:** `aluValid`, dest 5, data 0xDEADBEEF in cycle N. Required: `RegisterWrite`=1, `writeRegister`=5, `writeBack`=0xDEADBEEF in N+1 only. Register file reads back 0xDEADBEEF.
- **Contention:** MDU dest 7 = 0x11, then ALU dest 8 for 3 consecutive cycles. Required: three ALU writes first, then dest 7 = 0x11; `fifoCount` goes 1 then 0.
- **Squash:** MDU dest 9 = 0xAAAA buffered, then ALU dest 9 = 0xBBBB. Required:
  - only 0xBBBB is written;
  - the squashed pop cycle has `RegisterWrite`=0;
  - `pendingHit` for query 9 drops to 0 after the ALU write retires.
- **Full/backpressure:** hold the ALU busy with DEPTH+2 MDU offers. Required:
  - `mduReady`=0 after DEPTH accepts and `fifoCount`=DEPTH;
  - entries drain in order once the ALU goes idle.
- **`$0`:** ALU and MDU writes to dest 0. Required: no `RegisterWrite`, handshake completes, `pendingHit` for query 0 is always 0, FIFO unchanged.
